// File: rtl/regfile_countdown_ctrl.sv
// Walks register-file entries Base_Addr..Last_Addr (wrapping mod 16), counting each
// entry's value down to zero one Tick at a time and writing every decrement back.
module regfile_countdown_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              Abort,
  input  logic              Tick,
  input  logic [3:0]        Base_Addr,
  input  logic [3:0]        Last_Addr,
  output logic [3:0]        R_Addr,
  output logic              R_en,
  input  logic [DATA_W-1:0] R_Data,
  output logic [3:0]        W_Addr,
  output logic              W_en,
  output logic [DATA_W-1:0] W_Data,
  output logic              Busy,
  output logic              Done,
  output logic [3:0]        Cur_Addr,
  output logic [DATA_W-1:0] Cur_Value
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    COUNT,
    WRITE,
    NEXT,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [3:0]        last_q, last_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] cur_dec;
  logic              abort_run;

  assign cur_dec   = cur_q - DATA_W'(1);
  assign abort_run = Abort && (state_q != IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE: begin
        if (Start && !Abort) begin
          ptr_d   = Base_Addr;
          last_d  = Last_Addr;
          state_d = READ;
        end
      end
      READ: begin
        cur_d   = R_Data;
        state_d = COUNT;
      end
      COUNT: begin
        if (Tick) state_d = (cur_q != '0) ? WRITE : NEXT;
      end
      WRITE: begin
        // Only reachable with a non-zero value, so zero is never decremented.
        cur_d   = cur_dec;
        state_d = COUNT;
      end
      NEXT: begin
        if (ptr_q == last_q) begin
          state_d = FINISH;
        end else begin
          ptr_d   = ptr_q + 4'd1;
          state_d = READ;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort freezes pointer and value so the display keeps the interrupted entry.
    if (abort_run) begin
      state_d = IDLE;
      ptr_d   = ptr_q;
      last_d  = last_q;
      cur_d   = cur_q;
    end
  end

  assign R_en      = (state_q == READ);
  assign R_Addr    = ptr_q;
  assign W_en      = (state_q == WRITE) && !Abort;
  assign W_Addr    = ptr_q;
  assign W_Data    = W_en ? cur_dec : '0;
  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == FINISH) && !Abort;
  assign Cur_Addr  = ptr_q;
  assign Cur_Value = cur_q;

endmodule

// File: tb/tb_regfile_countdown_ctrl.sv
// Directed bench for regfile_countdown_ctrl: behavioural register file, queued
// expected reads/writes checked by a negedge monitor, directed status checks.
module tb_regfile_countdown_ctrl;

  localparam int unsigned DW = 8;

  logic          Clk = 1'b0;
  logic          Rst, Start, Abort, Tick;
  logic [3:0]    Base_Addr, Last_Addr;
  logic [3:0]    R_Addr, W_Addr, Cur_Addr;
  logic          R_en, W_en, Busy, Done;
  logic [DW-1:0] R_Data, W_Data, Cur_Value;

  logic [DW-1:0] mem [16];
  logic          preload;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;

  logic [3:0]    exp_rd [$];
  logic [3:0]    exp_wa [$];
  logic [DW-1:0] exp_wd [$];

  always #5 Clk = ~Clk;

  regfile_countdown_ctrl #(.DATA_W(DW)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort), .Tick(Tick),
    .Base_Addr(Base_Addr), .Last_Addr(Last_Addr),
    .R_Addr(R_Addr), .R_en(R_en), .R_Data(R_Data),
    .W_Addr(W_Addr), .W_en(W_en), .W_Data(W_Data),
    .Busy(Busy), .Done(Done), .Cur_Addr(Cur_Addr), .Cur_Value(Cur_Value)
  );

  function automatic logic [DW-1:0] init_val(input int unsigned a);
    case (a)
      3:       return DW'(2);
      5:       return DW'(47);
      7:       return DW'(3);
      4:       return DW'(5);
      default: return '0;
    endcase
  endfunction

  assign R_Data = mem[R_Addr];

  always @(posedge Clk) begin
    if (W_en) mem[W_Addr] <= W_Data;
    else if (preload)
      for (int unsigned i = 0; i < 16; i++) mem[i] <= init_val(i);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Done) done_cnt++;
    if (R_en) begin
      check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) check("rd_addr", 32'(R_Addr), 32'(exp_rd.pop_front()));
    end
    if (W_en) begin
      wr_cnt++;
      check("wr_expected", 32'(exp_wa.size() != 0), 32'd1);
      if (exp_wa.size() != 0) begin
        check("wr_addr", 32'(W_Addr), 32'(exp_wa.pop_front()));
        check("wr_data", 32'(W_Data), 32'(exp_wd.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd0);
    check({tag, "_ren"}, 32'(R_en), 32'd0);
    check({tag, "_wen"}, 32'(W_en), 32'd0);
    check({tag, "_raddr"}, 32'(R_Addr), 32'd0);
    check({tag, "_waddr"}, 32'(W_Addr), 32'd0);
    check({tag, "_wdata"}, 32'(W_Data), 32'd0);
    check({tag, "_curaddr"}, 32'(Cur_Addr), 32'd0);
    check({tag, "_curval"}, 32'(Cur_Value), 32'd0);
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [DW-1:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
  endtask

  task automatic start_run(input logic [3:0] b, input logic [3:0] l);
    Base_Addr = b;
    Last_Addr = l;
    Start     = 1'b1;
    exp_rd.push_back(b);
    step();
    Start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] seq [4];
    int d0;
    int w0;
    seq = '{4'd14, 4'd15, 4'd0, 4'd1};

    Rst = 1'b1; preload = 1'b1; Start = 1'b0; Abort = 1'b0; Tick = 1'b0;
    Base_Addr = '0; Last_Addr = '0;
    step(); step();
    Rst = 1'b0; preload = 1'b0;
    check_reset_outputs("reset");

    // Single entry 3 holding 2: two writes then Done.
    d0 = done_cnt;
    start_run(4'd3, 4'd3);
    check("t1_ren", 32'(R_en), 32'd1);
    check("t1_busy", 32'(Busy), 32'd1);
    step();
    check("t1_ren_one_cycle", 32'(R_en), 32'd0);
    check("t1_cur_loaded", 32'(Cur_Value), 32'd2);
    for (int k = 1; k >= 0; k--) begin
      Tick = 1'b1; push_wr(4'd3, DW'(k));
      step();
      Tick = 1'b0;
      check("t1_wen_latency", 32'(W_en), 32'd1);
      step();
      check("t1_cur_dec", 32'(Cur_Value), 32'(k));
    end
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    check("t1_done_early", 32'(Done), 32'd0);
    step();
    check("t1_done", 32'(Done), 32'd1);
    step();
    check("t1_done_pulse", 32'(Done), 32'd0);
    check("t1_busy_after", 32'(Busy), 32'd0);
    check("t1_mem3", 32'(mem[3]), 32'd0);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Wrapping run 14,15,0,1 of zero entries.
    d0 = done_cnt; w0 = wr_cnt;
    start_run(4'd14, 4'd1);
    for (int i = 1; i < 4; i++) exp_rd.push_back(seq[i]);
    step();
    for (int i = 0; i < 4; i++) begin
      Tick = 1'b1;
      step();
      Tick = 1'b0;
      step();
      if (i < 3) begin
        check("t2_cur_addr", 32'(Cur_Addr), 32'(seq[i+1]));
        step();
      end
    end
    check("t2_done", 32'(Done), 32'd1);
    step();
    check("t2_busy_after", 32'(Busy), 32'd0);
    check("t2_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t2_rd_drained", 32'(exp_rd.size()), 32'd0);

    // Abort after two decrements of 47.
    d0 = done_cnt;
    start_run(4'd5, 4'd5);
    step();
    for (int k = 46; k >= 45; k--) begin
      Tick = 1'b1; push_wr(4'd5, DW'(k));
      step();
      Tick = 1'b0;
      step();
    end
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    check("t3_idle", 32'(Busy), 32'd0);
    check("t3_cur_val", 32'(Cur_Value), 32'd45);
    check("t3_cur_addr", 32'(Cur_Addr), 32'd5);
    step(); step();
    check("t3_mem5", 32'(mem[5]), 32'd45);
    check("t3_no_done", 32'(done_cnt - d0), 32'd0);

    // Ticks in IDLE, READ and WRITE ignored; only one counted in COUNT.
    Tick = 1'b1;
    start_run(4'd7, 4'd7);
    step();
    Tick = 1'b0;
    step();
    check("t4_cur_after_read", 32'(Cur_Value), 32'd3);
    check("t4_no_wen", 32'(W_en), 32'd0);
    Tick = 1'b1; push_wr(4'd7, DW'(2));
    step();
    step();
    Tick = 1'b0;
    check("t4_write_tick_ignored", 32'(W_en), 32'd0);
    check("t4_cur", 32'(Cur_Value), 32'd2);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    step();
    check("t4_mem7", 32'(mem[7]), 32'd2);

    // Start held during a run with a different base.
    start_run(4'd9, 4'd9);
    Start = 1'b1; Base_Addr = 4'd2;
    step();
    check("t5_ptr_held", 32'(Cur_Addr), 32'd9);
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    check("t5_ptr_next", 32'(Cur_Addr), 32'd9);
    step();
    Start = 1'b0;
    check("t5_done", 32'(Done), 32'd1);
    step();
    check("t5_idle", 32'(Busy), 32'd0);
    check("t5_cur_addr", 32'(Cur_Addr), 32'd9);

    // Reset in COUNT with Tick pending: no write.
    w0 = wr_cnt;
    start_run(4'd4, 4'd4);
    step();
    Tick = 1'b1; Rst = 1'b1;
    step();
    Tick = 1'b0; Rst = 1'b0;
    check_reset_outputs("t6");
    step();
    check("t6_no_write", 32'(wr_cnt - w0), 32'd0);
    check("t6_mem4", 32'(mem[4]), 32'd5);
    check("wr_drained", 32'(exp_wa.size()), 32'd0);
    check("rd_drained", 32'(exp_rd.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_countdown_ctrl.md
REGFILE_COUNTDOWN_CTRL -- requirements
Module: regfile_countdown_ctrl

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 8, the register-file data width.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port Start, input, 1 bit: request to begin a countdown run.
REQ-005 The block SHALL have port Abort, input, 1 bit: terminate the run immediately.
REQ-006 The block SHALL have port Tick, input, 1 bit: single-cycle countdown step strobe.
REQ-007 The block SHALL have ports Base_Addr and Last_Addr, inputs, 4 bits each: first and last register-file entries of the run.
REQ-008 The block SHALL have ports R_Addr (output, 4 bits), R_en (output, 1 bit) and R_Data (input, DATA_W bits): the combinational register-file read port.
REQ-009 The block SHALL have ports W_Addr (output, 4 bits), W_en (output, 1 bit) and W_Data (output, DATA_W bits): the register-file write port.
REQ-010 The block SHALL have ports Busy (output, 1 bit), Done (output, 1 bit pulse), Cur_Addr (output, 4 bits) and Cur_Value (output, DATA_W bits): status and display values.

Function
REQ-011 The FSM SHALL have the states IDLE, READ, COUNT, WRITE, NEXT and FINISH, registered and one-hot or binary-encoded.
REQ-012 IDLE SHALL, on Start=1 and Abort=0, latch Base_Addr into ptr and Last_Addr into last, and go to READ.
REQ-013 Start SHALL be ignored in every state except IDLE.
REQ-014 READ SHALL drive R_en=1 and R_Addr=ptr for exactly one cycle, capture R_Data into Cur_Value at the clock edge, and go to COUNT.
REQ-015 Outside READ, R_en SHALL be 0 and R_Addr SHALL hold ptr.
REQ-016 COUNT SHALL wait for Tick.
REQ-017 In COUNT, Tick with Cur_Value!=0 SHALL go to WRITE.
REQ-018 In COUNT, Tick with Cur_Value==0 SHALL go to NEXT.
REQ-019 WRITE SHALL assert W_en=1, W_Addr=ptr and W_Data=Cur_Value-1 for exactly one cycle, load Cur_Value with Cur_Value-1, and return to COUNT.
REQ-020 W_en SHALL be 0 in every state except WRITE.
REQ-021 Tick SHALL be ignored, and not queued, in IDLE, READ, WRITE, NEXT and FINISH.
REQ-022 NEXT SHALL go to FINISH when ptr==last.
REQ-023 When ptr!=last, NEXT SHALL set ptr to ptr+1 modulo 16 (15 wraps to 0) and go to READ.
REQ-024 A run with Base_Addr>Last_Addr SHALL wrap through entry 15 to entry 0.
REQ-025 A run with Base_Addr==Last_Addr SHALL process exactly one entry.
REQ-026 FINISH SHALL assert Done=1 for exactly one cycle and go to IDLE.
REQ-027 Abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with no write, no Done pulse, and Cur_Addr and Cur_Value held.
REQ-028 Abort SHALL win over Start and over Tick in the same cycle.
REQ-029 Busy SHALL be 1 in every state except IDLE.
REQ-030 Cur_Addr SHALL equal ptr at all times.
REQ-031 Decrement SHALL use DATA_W-bit unsigned arithmetic, and a 0 value SHALL never be decremented.
REQ-032 Latency SHALL be: Start to first R_en is 1 cycle; Tick in COUNT to W_en is 1 cycle; final zero Tick to Done is 2 cycles.

Reset
REQ-033 Rst=1 at a clock edge SHALL force IDLE, ptr=0, last=0, Cur_Value=0, Busy=0, Done=0, R_en=0 and W_en=0, with R_Addr, W_Addr and W_Data all 0.
REQ-034 Rst SHALL take priority over Start, Abort and Tick.
REQ-035 Rst asserted mid-run SHALL abandon the run with no further register-file write.

Verification
REQ-036 Bench SHALL cover: Base=3, Last=3, entry 3=2; Start, then Tick x3 -> writes 1 then 0 to addr 3, a single Done pulse 2 cycles after the third Tick, Busy low after.
REQ-037 Bench SHALL cover: Base=14, Last=1, entries 14,15,0,1 all =0; Tick each entry -> READ order 14,15,0,1 (wrap), no W_en, one Done.
REQ-038 Bench SHALL cover: entry 5=47, Base=Last=5; Tick x2, then Abort -> entry 5=45, IDLE next cycle, no Done, Cur_Value=45.
REQ-039 Bench SHALL cover: Tick asserted during READ and WRITE cycles -> ignored; the decrement count equals the number of Ticks seen in COUNT only.
REQ-040 Bench SHALL cover: Start held while Busy with different Base_Addr -> run unaffected, ptr unchanged.
REQ-041 Bench SHALL cover: Rst pulsed while in WRITE-bound COUNT with Tick=1 -> no W_en, all outputs at REQ-033 values next cycle.
